uart_byte_bridge: RTL
=====================

Name: uart_byte_bridge

Overview:
- Client-side end of the UART byte handshake. Buffers outgoing bytes and meters them into the transmitter's `load`/`d`/`txbusy` interface.
- Captures the receiver's one-cycle `bytercvd`/`q` strobes into a FIFO. Flags overrun when the FIFO cannot accept a byte.
- Presents valid/ready byte streams to the rest of the design, so no client has to track `txbusy` timing or catch single-cycle strobes.

Parameters:
- TX_DEPTH_LOG2, 4, log2 of TX FIFO depth (16 entries).
- RX_DEPTH_LOG2, 4, log2 of RX FIFO depth (16 entries).

Ports:
- clk  in  1  system clock, same clock as the UART.
- rst  in  1  synchronous, active-high reset.
- tx_data  in  8  byte to transmit.
- tx_valid  in  1  tx_data offered.
- tx_ready  out  1  TX FIFO accepts; transfer when tx_valid & tx_ready.
- rx_data  out  8  head of RX FIFO (show-ahead).
- rx_valid  out  1  RX FIFO non-empty.
- rx_ready  in  1  consumer pops head when rx_valid & rx_ready.
- uart_load  out  1  one-cycle load strobe to the transmitter.
- uart_d  out  8  byte to the transmitter; valid while uart_load is high.
- uart_txbusy  in  1  transmitter busy.
- uart_bytercvd  in  1  receiver strobe, high exactly 1 cycle.
- uart_q  in  8  received byte, sampled when uart_bytercvd is high.
- rx_overrun  out  1  sticky flag: a received byte was dropped.
- ovr_clr  in  1  clears rx_overrun.
- tx_level  out  TX_DEPTH_LOG2+1  TX FIFO occupancy.
- rx_level  out  RX_DEPTH_LOG2+1  RX FIFO occupancy.

Behaviour:
- Reset, synchronous while rst is high, takes effect at the next clk edge:
  - all FIFO pointers and levels go to 0; FSM goes to IDLE.
  - uart_load=0, uart_d=0, rx_overrun=0, rx_valid=0.
  - tx_ready is forced 0 while rst is high.
  - FIFO contents are don't-care.
- TX FIFO:
  - tx_ready = !rst & (tx_level != 2^TX_DEPTH_LOG2).
  - A push when full is impossible. A same-cycle pop does not raise tx_ready; ready depends on full only.
- TX FSM, three states:
  - IDLE: if TX FIFO is non-empty and uart_txbusy=0, pop the head into the uart_d register and assert uart_load for exactly 1 cycle. Go to LOAD.
  - LOAD: uart_load=0 and uart_d held. Unconditionally go to WAIT. The transmitter raises txbusy the cycle after load; this guard cycle prevents a double load.
  - WAIT: stay until uart_txbusy=0, then go to IDLE.
  - Minimum spacing between uart_load pulses is 3 cycles; back-to-back spacing is otherwise set by txbusy.
  - Latency from a push into an empty FIFO with txbusy=0 to uart_load: 1 cycle. Push at edge N, uart_load high in cycle N+1.
  - uart_d is registered. It changes only when the FSM leaves IDLE, and stays stable until the next load.
- RX FIFO:
  - Push when uart_bytercvd=1, capturing uart_q that same cycle.
  - Show-ahead: rx_data = mem[rd_ptr], valid whenever rx_level > 0.
  - Pop when rx_valid & rx_ready.
  - Full, bytercvd and pop in the same cycle: the byte is accepted, there is no overrun, and the level stays full.
  - Full, bytercvd and no pop: the byte is dropped, FIFO contents are unchanged, and rx_overrun is set the next cycle.
  - Empty with pop requested: ignored, since rx_valid=0.
  - Empty with push: rx_valid rises the next cycle.
- rx_overrun:
  - Set on a drop; cleared by ovr_clr.
  - A drop and ovr_clr in the same cycle: set wins.
- Pointers are binary modulo 2^DEPTH_LOG2 and wrap silently. Levels are one bit wider, so full and empty are unambiguous.
- Mid-operation reset:
  - Any in-flight FSM state returns to IDLE.
  - A byte already handed to the UART completes on the line; the bridge does not abort it.
  - After reset the bridge waits for txbusy=0 before the next load.
- No combinational path from uart_txbusy or uart_bytercvd to any output.

Decomposition:
- Shared package holds:
  - constant UART_BYTE_W = 8.
  - TX FSM state enum {IDLE, LOAD, WAIT}, 2-bit encoding.
- One natural sub-module, byte_fifo, instantiated twice:
  - parameter DEPTH_LOG2.
  - ports push, din, pop, dout (show-ahead), full, empty, level.
  - synchronous reset.
  - documented rule: a push while full is accepted only when pop is high in the same cycle.

Test Plan:
- Single byte: push 0xA5 with txbusy=0 -> uart_load high 1 cycle later with uart_d=0xA5; no further uart_load; tx_level 1->0.
- Back-to-back TX: push 0x01,0x02,0x03; model txbusy high for 20 cycles after each load -> exactly 3 loads in order 0x01,0x02,0x03; each load only after txbusy falls; spacing >=3 cycles.
- TX full: push 17 bytes with txbusy held 1 -> tx_ready=0 after 16 accepted, tx_level=16; release txbusy -> all 16 bytes loaded in order and byte 17 accepted after the first pop.
- RX capture and overrun: 16 bytercvd strobes 0x10..0x1F with rx_ready=0, then 0x55 -> rx_level=16, rx_overrun=1, draining yields 0x10..0x1F with 0x55 absent; ovr_clr pulse -> rx_overrun=0.
- RX full with simultaneous pop: FIFO full, bytercvd=0x77 in the same cycle as a pop -> no overrun, rx_level stays 16, 0x77 emerges last.
- Reset mid-transfer: assert rst in LOAD/WAIT with 5 bytes queued -> next cycle tx_level=0, rx_level=0, uart_load=0, rx_overrun=0; tx_ready=0 while rst is high and 1 after release.

Source files
------------

// File: rtl/uart_byte_bridge_pkg.sv
// Shared definitions for the UART byte bridge: byte width and TX sequencer states.
package uart_byte_bridge_pkg;

    localparam int UART_BYTE_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        WAIT = 2'd2
    } tx_state_e;

endpackage

// File: rtl/uart_byte_bridge_byte_fifo.sv
// Show-ahead byte FIFO with synchronous reset and a level one bit wider than the pointers.
// A push while full is accepted only when a pop happens in the same cycle.
module byte_fifo
    import uart_byte_bridge_pkg::*;
#(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   push_i,
    input  logic [UART_BYTE_W-1:0] din_i,
    input  logic                   pop_i,
    output logic [UART_BYTE_W-1:0] dout_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [DEPTH_LOG2:0]    level_o
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [UART_BYTE_W-1:0] mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0]  wr_ptr_q;
    logic [DEPTH_LOG2-1:0]  rd_ptr_q;
    logic [DEPTH_LOG2:0]    level_q;
    logic                   push_ok;
    logic                   pop_ok;

    // Level never exceeds DEPTH, so its top bit alone marks full.
    assign full_o  = level_q[DEPTH_LOG2];
    assign empty_o = (level_q == '0);
    assign level_o = level_q;
    assign dout_o  = mem_q[rd_ptr_q];

    assign pop_ok  = pop_i && !empty_o;
    assign push_ok = push_i && (!full_o || pop_ok);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   level_q <= level_q + 1'b1;
                2'b01:   level_q <= level_q - 1'b1;
                default: level_q <= level_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_ok) mem_q[wr_ptr_q] <= din_i;
    end

endmodule

// File: rtl/uart_byte_bridge.sv
// Client side of the UART byte handshake: buffers TX bytes into load/d/txbusy, RX strobes into a FIFO.
// state | meaning:  IDLE | wait for a queued byte and txbusy low ; LOAD | load strobe issued, guard cycle ; WAIT | wait for txbusy low
module uart_byte_bridge
    import uart_byte_bridge_pkg::*;
#(
    parameter int TX_DEPTH_LOG2 = 4,
    parameter int RX_DEPTH_LOG2 = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [UART_BYTE_W-1:0] tx_data_i,
    input  logic                   tx_valid_i,
    output logic                   tx_ready_o,
    output logic [UART_BYTE_W-1:0] rx_data_o,
    output logic                   rx_valid_o,
    input  logic                   rx_ready_i,
    output logic                   uart_load_o,
    output logic [UART_BYTE_W-1:0] uart_d_o,
    input  logic                   uart_txbusy_i,
    input  logic                   uart_bytercvd_i,
    input  logic [UART_BYTE_W-1:0] uart_q_i,
    output logic                   rx_overrun_o,
    input  logic                   ovr_clr_i,
    output logic [TX_DEPTH_LOG2:0] tx_level_o,
    output logic [RX_DEPTH_LOG2:0] rx_level_o
);

    tx_state_e              state_q;
    logic                   uart_load_q;
    logic [UART_BYTE_W-1:0] uart_d_q;
    logic                   rx_overrun_q;

    logic [UART_BYTE_W-1:0] tx_head;
    logic                   tx_full, tx_empty, tx_push, tx_pop;
    logic                   rx_full, rx_empty, rx_pop, rx_drop;

    assign tx_ready_o = !rst_i && !tx_full;
    assign tx_push    = tx_valid_i && tx_ready_o;
    assign tx_pop     = (state_q == IDLE) && !tx_empty && !uart_txbusy_i;

    assign rx_valid_o = !rx_empty;
    assign rx_pop     = rx_valid_o && rx_ready_i;
    assign rx_drop    = uart_bytercvd_i && rx_full && !rx_pop;

    assign uart_load_o  = uart_load_q;
    assign uart_d_o     = uart_d_q;
    assign rx_overrun_o = rx_overrun_q;

    byte_fifo #(.DEPTH_LOG2(TX_DEPTH_LOG2)) u_tx_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (tx_push),
        .din_i   (tx_data_i),
        .pop_i   (tx_pop),
        .dout_o  (tx_head),
        .full_o  (tx_full),
        .empty_o (tx_empty),
        .level_o (tx_level_o)
    );

    byte_fifo #(.DEPTH_LOG2(RX_DEPTH_LOG2)) u_rx_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (uart_bytercvd_i),
        .din_i   (uart_q_i),
        .pop_i   (rx_pop),
        .dout_o  (rx_data_o),
        .full_o  (rx_full),
        .empty_o (rx_empty),
        .level_o (rx_level_o)
    );

    // LOAD is a guard cycle: the transmitter only raises txbusy the cycle after it sees load.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            uart_load_q <= 1'b0;
            uart_d_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (tx_pop) begin
                        uart_d_q    <= tx_head;
                        uart_load_q <= 1'b1;
                        state_q     <= LOAD;
                    end
                end
                LOAD: begin
                    uart_load_q <= 1'b0;
                    state_q     <= WAIT;
                end
                WAIT: begin
                    if (!uart_txbusy_i) state_q <= IDLE;
                end
                default: begin
                    uart_load_q <= 1'b0;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i)             rx_overrun_q <= 1'b0;
        else if (rx_drop)      rx_overrun_q <= 1'b1;
        else if (ovr_clr_i)    rx_overrun_q <= 1'b0;
    end

endmodule
